// File: rtl/spu_regfile_sb.sv
// spu_regfile_sb -- N-lane SPU register file with a per-register busy scoreboard.
//
// Storage is a plain DEPTH x DATA_W array with no reset, so it can map to RAM.
// After reset, and after every clear_req, a sequential sweep writes zero to each
// row, one row per cycle, from row 0 up to row DEPTH-1. While the sweep runs the
// file reports init_done_o=0, reads return 0 and not-busy, and write-back, claim
// and clear requests are all ignored.
//
// Optional build macro: SPU_RF_WB_BYPASS_EN
//   defined   : a write-back in the current cycle is forwarded to any read port
//               that reads the same register (highest lane wins), and that port
//               reports not-busy in the same cycle.
//   undefined : reads show the array contents. A consumer sees the new value and
//               busy=0 one cycle after the write-back.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   reset_ni       asynchronous active-low reset
//   clear_req_i    single-cycle pulse that restarts the zero sweep (READY only)
//   init_done_o    1 when the file is usable
//   rd_addr_i      NRD read addresses; port p = lane p/RD_PER_LANE, slot p%RD_PER_LANE
//   rd_data_o      NRD read values, combinational
//   rd_busy_o      NRD busy flags for the source registers (1 = stall)
//   wb_en_i        per-lane write-back enable
//   wb_addr_i      per-lane write-back destination
//   wb_data_i      per-lane write-back value
//   claim_en_i     per-lane issue of a register-writing instruction
//   claim_addr_i   per-lane destination being claimed
//   claim_err_o    registered per-lane WAW flag (the claimed register was already busy)
module spu_regfile_sb #(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 7,
   parameter int NUM_LANES   = 2,
   parameter int RD_PER_LANE = 3
) (
   input  logic                              clk_i,
   input  logic                              reset_ni,
   input  logic                              clear_req_i,
   output logic                              init_done_o,
   input  logic [NUM_LANES*RD_PER_LANE*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_LANES*RD_PER_LANE*DATA_W-1:0] rd_data_o,
   output logic [NUM_LANES*RD_PER_LANE-1:0]        rd_busy_o,
   input  logic [NUM_LANES-1:0]              wb_en_i,
   input  logic [NUM_LANES*ADDR_W-1:0]       wb_addr_i,
   input  logic [NUM_LANES*DATA_W-1:0]       wb_data_i,
   input  logic [NUM_LANES-1:0]              claim_en_i,
   input  logic [NUM_LANES*ADDR_W-1:0]       claim_addr_i,
   output logic [NUM_LANES-1:0]              claim_err_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NRD   = NUM_LANES * RD_PER_LANE;
   localparam logic [ADDR_W-1:0] LAST_ROW = '1;

   typedef enum logic {S_INIT, S_READY} state_e;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [DEPTH-1:0]      busy_q, busy_d;
   logic [NUM_LANES-1:0]  claim_err_q, claim_err_d;
   logic [DATA_W-1:0]     mem_q [DEPTH];

   logic                  ready;
   logic [NUM_LANES-1:0]  wb_vld, clm_vld;

   // A clear request swallows any write-back or claim issued in the same cycle.
   assign ready   = (state_q == S_READY);
   assign wb_vld  = {NUM_LANES{ready & ~clear_req_i}} & wb_en_i;
   assign clm_vld = {NUM_LANES{ready & ~clear_req_i}} & claim_en_i;

   assign init_done_o = ready;
   assign claim_err_o = claim_err_q;

   // ---------------- sweep FSM ----------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_ROW) begin
               state_d = S_READY;
               idx_d   = '0;
            end
         end
         S_READY: begin
            if (clear_req_i) begin
               state_d = S_INIT;
               idx_d   = '0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // ---------------- scoreboard ----------------
   // Write-backs release first and claims set afterwards, so a claim and a
   // write-back to the same register in one cycle leave it busy (new producer).
   always_comb begin
      busy_d      = busy_q;
      claim_err_d = '0;
      if (ready && clear_req_i) busy_d = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (wb_vld[l]) busy_d[wb_addr_i[l*ADDR_W +: ADDR_W]] = 1'b0;
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         if (clm_vld[l]) begin
            claim_err_d[l] = busy_q[claim_addr_i[l*ADDR_W +: ADDR_W]];
            // A retiring producer frees the register, so no WAW.
            for (int k = 0; k < NUM_LANES; k++) begin
               if (wb_vld[k] && wb_addr_i[k*ADDR_W +: ADDR_W] == claim_addr_i[l*ADDR_W +: ADDR_W])
                  claim_err_d[l] = 1'b0;
            end
            // A lower lane claiming the same register this cycle makes the higher lane a WAW.
            for (int k = 0; k < NUM_LANES; k++) begin
               if (k < l && clm_vld[k] && claim_addr_i[k*ADDR_W +: ADDR_W] == claim_addr_i[l*ADDR_W +: ADDR_W])
                  claim_err_d[l] = 1'b1;
            end
            busy_d[claim_addr_i[l*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_INIT;
         idx_q       <= '0;
         busy_q      <= '0;
         claim_err_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         claim_err_q <= claim_err_d;
      end
   end

   // ---------------- storage (no reset) ----------------
   // Lanes are applied in ascending order so the highest lane wins an address clash.
   always_ff @(posedge clk_i) begin
      if (!ready) begin
         mem_q[idx_q] <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wb_vld[l]) mem_q[wb_addr_i[l*ADDR_W +: ADDR_W]] <= wb_data_i[l*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------- read ports ----------------
   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdat;
      logic              rb;

      assign ra = rd_addr_i[p*ADDR_W +: ADDR_W];

      always_comb begin
         rdat = mem_q[ra];
         rb   = busy_q[ra];
`ifdef SPU_RF_WB_BYPASS_EN
         for (int l = 0; l < NUM_LANES; l++) begin
            if (wb_vld[l] && wb_addr_i[l*ADDR_W +: ADDR_W] == ra) begin
               rdat = wb_data_i[l*DATA_W +: DATA_W];
               rb   = 1'b0;
            end
         end
`endif
         if (!ready) begin
            rdat = '0;
            rb   = 1'b0;
         end
      end

      assign rd_data_o[p*DATA_W +: DATA_W] = rdat;
      assign rd_busy_o[p]                  = rb;
   end

endmodule
